spi_byte_master: RTL
====================

// Module: spi_byte_master
// PURPOSE
//  Downstream stage of the UART receiver in the UART-to-SPI bridge. Takes one received byte per
//  ready/ack handshake, shifts it out MSB-first on SPI mode 0, and captures the simultaneous MISO
//  byte for the UART transmit path. Chip select stays asserted across back-to-back bytes and is
//  released after an idle timeout.
// PARAMETERS
//  SCK_HALF  4      sys_clk cycles per SCK half-period (H); legal range >= 2
//  CS_HOLD   20832  cycles CS is held low after a byte with no new byte; 0 = release immediately
// PORTS
//  sys_clk   in   1  single clock; all logic on rising edge
//  sys_rst   in   1  synchronous, active-high reset
//  in_data   in   8  byte from UART RX (rx_data)
//  in_ready  in   1  byte available, level, held until acked (rx_ready)
//  in_ack    out  1  one-cycle pulse; in_data is latched in this cycle (to rx_ack)
//  out_data  out  8  byte captured from MISO
//  out_valid out  1  out_data valid; held until out_ack
//  out_ack   in   1  consumer took out_data
//  spi_sck   out  1  SPI clock, idle low
//  spi_mosi  out  1  SPI data out
//  spi_miso  in   1  SPI data in
//  spi_cs_n  out  1  chip select, active low
// BEHAVIOUR
//  Reset: in_ack=0, out_data=0, out_valid=0, spi_sck=0, spi_mosi=0, spi_cs_n=1, state=IDLE, all counters 0.
//    Reset mid-transfer aborts immediately; the in-flight byte is lost; CS goes high the next cycle.
//  Accept condition: in_ready & ~out_valid (registered value) in IDLE or HOLD.
//    On accept: in_ack=1 for that one cycle; latch tx shift register; spi_mosi<=in_data[7];
//    spi_cs_n<=0; divider<=H-1; state->LEAD.
//  Divider: counts H-1 down to 0; tick when 0, then reloads H-1.
//  FSM:
//    IDLE   cs_n=1, sck=0; wait for accept.
//    LEAD   on tick: sck<=1 (rise 1), sample miso; ->SHIFT.
//    SHIFT  on each tick: toggle sck.
//           Rise: shift miso into rx LSB.
//           Fall: drive next tx bit on mosi.
//           8th fall: out_data<=rx byte, out_valid<=1, hold_cnt<=CS_HOLD; ->HOLD.
//    HOLD   cs_n=0, sck=0. Accept has priority (-> LEAD, CS stays low). Otherwise hold_cnt
//           decrements; in the cycle hold_cnt==0: cs_n<=1, divider<=H-1; ->DESEL.
//    DESEL  cs_n=1 for H cycles (one tick), then ->IDLE. No accept in DESEL.
//  Timing (in_ack at cycle T): cs_n low at T+1.
//    Rise k at T+1+(2k-1)H; fall k at T+1+2kH.
//    out_valid rises with the 8th fall at T+1+16H (T+65 for H=4).
//  out_valid clears the cycle after out_ack is sampled high; out_ack while out_valid=0 is ignored.
//  Backpressure: no new byte is accepted while out_valid=1, so captured data is never overwritten.
//  Simultaneous out_ack and in_ready: ack is taken first; accept happens no earlier than the next cycle.
//  hold_cnt width = $clog2(CS_HOLD+1).
//    CS_HOLD=0: with no pending accept, cs_n goes high the cycle after HOLD entry.
//    Otherwise cs_n goes high at E+CS_HOLD+1, where E = out_valid rise.
//  MISO is sampled on the internal rise-tick cycle; no synchronizer inside (system timing guarantees).
// TESTING
//  1. H=4, mosi looped to miso, in_data=0xA5
//     -> in_ack 1 cycle; mosi bits 1,0,1,0,0,1,0,1 at rises;
//        out_data=0xA5, out_valid at T+65; 16 sck edges.
//  2. miso driven 0x3C MSB-first, in_data=0x00
//     -> out_data=0x3C; mosi stays 0; cs_n low T+1..T+65+CS_HOLD.
//  3. Second byte presented, with out_ack, 10 cycles after first out_valid
//     -> cs_n never rises between bytes; second in_ack in HOLD.
//  4. CS_HOLD=8, no second byte
//     -> cs_n high exactly at E+9; stays high >= 4 cycles; then next byte accepted.
//  5. out_ack withheld 50 cycles with in_ready high
//     -> no in_ack until the cycle after out_ack; out_data unchanged meanwhile.
//  6. sys_rst at 5th rise
//     -> next cycle cs_n=1, sck=0, mosi=0, out_valid=0;
//        a fresh byte afterwards transfers correctly.

Source files
------------

// File: rtl/spi_byte_master.sv
// SPI mode-0 byte master for the UART-to-SPI bridge.
// One byte per in_ready/in_ack handshake; MISO byte returned on out_data/out_valid.
module spi_byte_master #(
    parameter int SCK_HALF = 4,
    parameter int CS_HOLD  = 20832
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] in_data,
    input  logic       in_ready,
    output logic       in_ack,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ack,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_cs_n
);

    localparam int DW = (SCK_HALF > 2) ? $clog2(SCK_HALF) : 1;
    localparam int HW = (CS_HOLD > 0) ? $clog2(CS_HOLD + 1) : 1;
    localparam logic [DW-1:0] DIV_LOAD  = DW'(SCK_HALF - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(CS_HOLD);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        HOLD,
        DESEL
    } state_t;

    state_t        state, state_next;
    logic [DW-1:0] div, div_next;
    logic [2:0]    bit_cnt, bit_next;
    logic [7:0]    tx, tx_next;
    logic [7:0]    rx, rx_next;
    logic [HW-1:0] hold_cnt, hold_next;
    logic          sck_next, mosi_next, cs_next, valid_next;
    logic [7:0]    data_next;
    logic          tick, accept;

    // Next-state and datapath updates; defaults keep every register unchanged.
    always_comb begin
        tick   = (div == '0);
        accept = !sys_rst && in_ready && !out_valid &&
                 (state == IDLE || state == HOLD);

        state_next = state;
        div_next   = div;
        bit_next   = bit_cnt;
        tx_next    = tx;
        rx_next    = rx;
        hold_next  = hold_cnt;
        sck_next   = spi_sck;
        mosi_next  = spi_mosi;
        cs_next    = spi_cs_n;
        data_next  = out_data;
        valid_next = out_valid;

        if (out_valid && out_ack) begin
            valid_next = 1'b0;
        end

        unique case (state)
            IDLE, HOLD: begin
                if (accept) begin
                    tx_next    = in_data;
                    rx_next    = '0;
                    bit_next   = '0;
                    mosi_next  = in_data[7];
                    cs_next    = 1'b0;
                    div_next   = DIV_LOAD;
                    state_next = LEAD;
                end else if (state == HOLD) begin
                    if (hold_cnt == '0) begin
                        cs_next    = 1'b1;
                        div_next   = DIV_LOAD;
                        state_next = DESEL;
                    end else begin
                        hold_next = hold_cnt - 1'b1;
                    end
                end
            end
            LEAD: begin
                div_next = tick ? DIV_LOAD : div - 1'b1;
                if (tick) begin
                    sck_next   = 1'b1;
                    rx_next    = {rx[6:0], spi_miso};
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                div_next = tick ? DIV_LOAD : div - 1'b1;
                if (tick) begin
                    sck_next = ~spi_sck;
                    if (spi_sck) begin
                        if (bit_cnt == 3'd7) begin
                            data_next  = rx;
                            valid_next = 1'b1;
                            hold_next  = HOLD_LOAD;
                            state_next = HOLD;
                        end else begin
                            tx_next   = {tx[6:0], 1'b0};
                            mosi_next = tx[6];
                            bit_next  = bit_cnt + 3'd1;
                        end
                    end else begin
                        rx_next = {rx[6:0], spi_miso};
                    end
                end
            end
            DESEL: begin
                div_next = tick ? DIV_LOAD : div - 1'b1;
                if (tick) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_ack = accept;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            div       <= '0;
            bit_cnt   <= '0;
            tx        <= '0;
            rx        <= '0;
            hold_cnt  <= '0;
            spi_sck   <= 1'b0;
            spi_mosi  <= 1'b0;
            spi_cs_n  <= 1'b1;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            div       <= div_next;
            bit_cnt   <= bit_next;
            tx        <= tx_next;
            rx        <= rx_next;
            hold_cnt  <= hold_next;
            spi_sck   <= sck_next;
            spi_mosi  <= mosi_next;
            spi_cs_n  <= cs_next;
            out_data  <= data_next;
            out_valid <= valid_next;
        end
    end

endmodule
